egress_arb: RTL

EGRESS_ARB -- requirements
Module: egress_arb

---
 rtl/egress_arb.sv | 90 +++++++++
 1 files changed

// File: rtl/egress_arb.sv
// egress_arb: round-robin arbiter multiplexing two-beat (address, data) transactions onto one egress port.
// The grant is held from the address beat through the data beat; a stalled grantee is aborted after TMO idle cycles.
module egress_arb #(
  parameter int NREQ = 4,
  parameter int TMO = 16
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_rdy,
  output logic [NREQ-1:0]   req_done,
  output logic [7:0]        req_rdata,
  output logic              int_datavalid,
  output logic [7:0]        int2eg_data,
  input  logic              int_datardy,
  input  logic [7:0]        eg2int_data,
  output logic [2:0]        gnt_id,
  output logic              busy,
  output logic              tmo_err
);
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_ADDR = 2'd1;
  localparam logic [1:0] ARB_DATA = 2'd2;
  logic [1:0] state;
  logic [2:0] ptr;
  logic [2:0] win;
  logic [7:0] stall;
  logic [7:0] sel_data;
  logic       sel_valid;
  logic       any;
  logic       xfer;
  // Search runs from the farthest candidate down so the nearest one after ptr overwrites last.
  always_comb begin
    sel_valid = 1'b0;
    sel_data = 8'h00;
    win = 3'd0;
    any = 1'b0;
    req_rdy = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == 3'(i)) begin
        sel_valid = req_valid[i];
        sel_data = req_data[8*i +: 8];
      end
    end
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(ptr) + k) % NREQ]) begin
        any = 1'b1;
        win = 3'((int'(ptr) + k) % NREQ);
      end
    end
    for (int i = 0; i < NREQ; i++) req_rdy[i] = busy && gnt_id == 3'(i) && int_datardy;
  end
  assign busy = state == ARB_ADDR || state == ARB_DATA;
  assign xfer = busy && sel_valid && int_datardy;
  assign tmo_err = busy && !xfer && stall == 8'(TMO);
  assign int_datavalid = busy && sel_valid;
  assign int2eg_data = busy ? sel_data : 8'h00;
  assign req_rdata = eg2int_data;
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= ARB_IDLE;
      ptr <= 3'(NREQ - 1);
      gnt_id <= 3'd0;
      stall <= 8'd0;
      req_done <= '0;
    end else begin
      req_done <= '0;
      if (!busy) begin
        state <= any ? ARB_ADDR : ARB_IDLE;
        if (any) begin
          gnt_id <= win;
          stall <= 8'd0;
        end
      end else if (xfer) begin
        stall <= 8'd0;
        state <= state == ARB_ADDR ? ARB_DATA : ARB_IDLE;
        if (state == ARB_DATA) begin
          ptr <= gnt_id;
          req_done <= {{(NREQ-1){1'b0}}, 1'b1} << gnt_id;
        end
      end else if (tmo_err) begin
        state <= ARB_IDLE;
        stall <= 8'd0;
      end else if (!sel_valid) begin
        stall <= stall + 8'd1;
      end
    end
  end
endmodule
